// File: rtl/xalu_pkg.sv
// Shared definitions for the sequential ALU: function codes, FSM states and small helpers.
package xalu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_ADC   = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd2;
    localparam logic [OP_W-1:0] OP_AND   = 4'd3;
    localparam logic [OP_W-1:0] OP_OR    = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd5;
    localparam logic [OP_W-1:0] OP_PASSA = 4'd6;
    localparam logic [OP_W-1:0] OP_PASSB = 4'd7;
    localparam logic [OP_W-1:0] OP_SHL1  = 4'd8;
    localparam logic [OP_W-1:0] OP_SHR1  = 4'd9;
    localparam logic [OP_W-1:0] OP_SHLN  = 4'd10;
    localparam logic [OP_W-1:0] OP_SHRN  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Multi-bit shifts are the only ops that may take more than one cycle.
    function automatic logic is_nshift(input logic [OP_W-1:0] code);
        return (code == OP_SHLN) || (code == OP_SHRN);
    endfunction

endpackage

// File: rtl/xalu_datapath.sv
// Combinational single-step function unit: adder, logic, pass and one-bit shifts with carry out.
module xalu_datapath
    import xalu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             cupd
);

    localparam int unsigned SW = WIDTH + 1;

    logic [SW-1:0] sum;

    always_comb begin
        sum  = '0;
        r    = a;
        cout = 1'b0;
        cupd = 1'b1;
        case (op)
            OP_ADD: begin
                sum  = {1'b0, a} + {1'b0, b};
                r    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
            end
            OP_ADC: begin
                sum  = {1'b0, a} + {1'b0, b} + SW'(cin);
                r    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
            end
            // Carry out of SUB is the inverted borrow: 1 when a >= b.
            OP_SUB: begin
                sum  = {1'b0, a} + {1'b0, ~b} + SW'(1);
                r    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
            end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_PASSA: r = a;
            OP_PASSB: r = b;
            OP_SHL1: begin
                r    = {a[WIDTH-2:0], cin};
                cout = a[WIDTH-1];
            end
            OP_SHR1: begin
                r    = {cin, a[WIDTH-1:1]};
                cout = a[0];
            end
            // One zero-filled step of a multi-bit shift; the top iterates it.
            OP_SHLN: begin
                r    = {a[WIDTH-2:0], 1'b0};
                cout = a[WIDTH-1];
            end
            OP_SHRN: begin
                r    = {1'b0, a[WIDTH-1:1]};
                cout = a[0];
            end
            default: begin
                r    = a;
                cupd = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/xalu_seq.sv
// Sequential ALU: handshaked operand intake, iterative shifter, accumulator and registered result/flags.
module xalu_seq
    import xalu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             src_acc,
    input  logic             acc_we,
    input  logic             com,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             neg_zero,
    output logic             equ,
    output logic [WIDTH-1:0] acc
);

    state_e           state;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic             com_q;
    logic             acc_we_q;
    logic             equ_q;

    logic             accept_c;
    logic             in_shift_c;
    logic             go_shift_c;
    logic             finish_c;
    logic             keep_a_c;
    logic             carry_upd_c;
    logic             com_sel_c;
    logic             we_sel_c;
    logic             eq_sel_c;
    logic [SHW-1:0]   count_c;
    logic [OP_W-1:0]  dp_op_c;
    logic [WIDTH-1:0] a_sel_c;
    logic [WIDTH-1:0] dp_a_c;
    logic [WIDTH-1:0] dp_b_c;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] res_c;
    logic [WIDTH-1:0] dp_r;
    logic             dp_cout;
    logic             dp_cupd;

    // A new op may enter while idle, or while the held result is being taken.
    assign in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);

    always_comb begin
        accept_c    = in_valid && in_ready;
        in_shift_c  = (state == ST_SHIFT);
        a_sel_c     = src_acc ? acc : a_in;
        count_c     = b_in[SHW-1:0];
        dp_op_c     = in_shift_c ? op_q : op;
        dp_a_c      = in_shift_c ? work : a_sel_c;
        dp_b_c      = in_shift_c ? '0 : b_in;
        keep_a_c    = !in_shift_c && is_nshift(op) && (count_c == '0);
        go_shift_c  = accept_c && is_nshift(op) && (count_c > SHW'(1));
        finish_c    = in_shift_c ? (cnt == SHW'(1)) : (accept_c && !go_shift_c);
        r_c         = keep_a_c ? a_sel_c : dp_r;
        com_sel_c   = in_shift_c ? com_q : com;
        res_c       = com_sel_c ? ~r_c : r_c;
        carry_upd_c = dp_cupd && !keep_a_c;
        we_sel_c    = in_shift_c ? acc_we_q : acc_we;
        eq_sel_c    = in_shift_c ? equ_q : (a_sel_c == b_in);
    end

    xalu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .op   (dp_op_c),
        .a    (dp_a_c),
        .b    (dp_b_c),
        .cin  (carry),
        .r    (dp_r),
        .cout (dp_cout),
        .cupd (dp_cupd)
    );

    // FSM, shift iterator and all architectural state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            work      <= '0;
            cnt       <= '0;
            com_q     <= 1'b0;
            acc_we_q  <= 1'b0;
            equ_q     <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            neg_zero  <= 1'b0;
            equ       <= 1'b0;
            acc       <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if ((state == ST_HOLD) && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                    if (accept_c) begin
                        op_q      <= op;
                        com_q     <= com;
                        acc_we_q  <= acc_we;
                        equ_q     <= eq_sel_c;
                        // First shift step happens on the accept edge.
                        work      <= dp_r;
                        cnt       <= count_c - SHW'(1);
                        state     <= go_shift_c ? ST_SHIFT : ST_HOLD;
                        out_valid <= !go_shift_c;
                    end
                end
                ST_SHIFT: begin
                    work <= dp_r;
                    cnt  <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase

            if (finish_c) begin
                result   <= res_c;
                zero     <= (res_c == '0);
                neg_zero <= &res_c;
                equ      <= eq_sel_c;
                if (carry_upd_c) begin
                    carry <= dp_cout;
                end
                if (we_sel_c) begin
                    acc <= res_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_xalu_seq.sv
// Self-checking bench for xalu_seq (WIDTH=8): transaction-level model plus directed literal checks.
module tb_xalu_seq;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       op = '0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             src_acc = 1'b0;
    logic             acc_we = 1'b0;
    logic             com = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             neg_zero;
    logic             equ;
    logic [WIDTH-1:0] acc;

    xalu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .src_acc   (src_acc),
        .acc_we    (acc_we),
        .com       (com),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .neg_zero  (neg_zero),
        .equ       (equ),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       nz;
        logic       eq;
        logic [7:0] acc;
        int         lat;
        int         acc_cyc;
        bit         seen;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] m_acc = '0;
    logic       m_c = 1'b0;

    // Stream of mixed ops sent back to back.
    int s_op [14] = '{5, 3, 4, 7, 6, 8, 9, 11, 10, 11, 13, 1, 11, 10};
    int s_a  [14] = '{8'h3C, 8'hA5, 8'hA0, 8'h00, 8'h66, 8'h80, 8'h01, 8'hB4, 8'h40, 8'h81, 8'h12, 8'h7F, 8'hF0, 8'h01};
    int s_b  [14] = '{8'h0F, 8'h0F, 8'h05, 8'h77, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01, 8'h01, 8'h34, 8'h80, 8'h07, 8'h07};
    bit s_sa [14] = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    bit s_we [14] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    bit s_cm [14] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Operation semantics written as plain integer arithmetic on 8-bit values.
    function automatic void model_accept(input int opc, input int a, input int b,
                                         input bit sa, input bit we, input bit cm);
        int   av;
        int   r;
        int   c;
        int   n;
        int   lat;
        exp_t e;
        av  = sa ? int'(m_acc) : a;
        c   = int'(m_c);
        n   = b % 8;
        lat = 1;
        case (opc)
            0: begin r = av + b; c = (r >> 8) & 1; end
            1: begin r = av + b + int'(m_c); c = (r >> 8) & 1; end
            2: begin r = av - b; c = (av >= b) ? 1 : 0; end
            3: begin r = av & b; c = 0; end
            4: begin r = av | b; c = 0; end
            5: begin r = av ^ b; c = 0; end
            6: begin r = av; c = 0; end
            7: begin r = b; c = 0; end
            8: begin r = (av << 1) | int'(m_c); c = (av >> 7) & 1; end
            9: begin r = (av >> 1) | (int'(m_c) << 7); c = av & 1; end
            10: begin
                r = av;
                if (n != 0) begin r = av << n; c = (av >> (8 - n)) & 1; end
                if (n >= 2) lat = n;
            end
            11: begin
                r = av;
                if (n != 0) begin r = av >> n; c = (av >> (n - 1)) & 1; end
                if (n >= 2) lat = n;
            end
            default: r = av;
        endcase
        r = r & 255;
        if (cm) r = (~r) & 255;
        e.res = 8'(r);
        e.c   = (c != 0);
        e.z   = (r == 0);
        e.nz  = (r == 255);
        e.eq  = (av == b);
        m_c   = (c != 0);
        if (we) m_acc = 8'(r);
        e.acc     = m_acc;
        e.lat     = lat;
        e.acc_cyc = cyc;
        e.seen    = 1'b0;
        q.push_back(e);
    endfunction

    // Per-cycle comparison of DUT outputs against the model's queued expectations.
    always @(negedge clk) begin
        bit pending;
        if (rst_n) begin
            pending = 1'b0;
            if (q.size() > 0) pending = (cyc > q[0].acc_cyc);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("valid_without_op", 32'(out_valid), 32'd0);
                end else begin
                    if (!q[0].seen) begin
                        check("latency", 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
                        q[0].seen = 1'b1;
                    end
                    check("result", 32'(result), 32'(q[0].res));
                    check("carry", 32'(carry), 32'(q[0].c));
                    check("zero", 32'(zero), 32'(q[0].z));
                    check("neg_zero", 32'(neg_zero), 32'(q[0].nz));
                    check("equ", 32'(equ), 32'(q[0].eq));
                    check("acc", 32'(acc), 32'(q[0].acc));
                    check("in_ready_hold", 32'(in_ready), 32'(out_ready));
                    if (out_ready) void'(q.pop_front());
                end
            end else begin
                check("in_ready", 32'(in_ready), pending ? 32'd0 : 32'd1);
                if (pending && (cyc - q[0].acc_cyc >= q[0].lat)) begin
                    check("out_valid_due", 32'(out_valid), 32'd1);
                    void'(q.pop_front());
                end
            end
        end
    end

    // Offer one op from posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int opc, input int a, input int b, input bit sa, input bit we, input bit cm);
        int guard;
        guard    = 0;
        op       = 4'(opc);
        a_in     = 8'(a);
        b_in     = 8'(b);
        src_acc  = sa;
        acc_we   = we;
        com      = cm;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            model_accept(opc, a, b, sa, we, cm);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = ~op;
        a_in     = ~a_in;
        b_in     = ~b_in;
        src_acc  = ~src_acc;
        acc_we   = 1'b0;
        com      = ~com;
    endtask

    task automatic expect_lit(input string name, input logic [7:0] r, input bit c, input bit z,
                              input bit nz, input bit eq, input int lat);
        int n;
        @(negedge clk);
        n = 1;
        while (!out_valid && n < 50) begin
            check({name, "_busy_in_ready"}, 32'(in_ready), 32'd0);
            n++;
            @(negedge clk);
        end
        check({name, "_lat"}, 32'(n), 32'(lat));
        check({name, "_res"}, 32'(result), 32'(r));
        check({name, "_carry"}, 32'(carry), 32'(c));
        check({name, "_zero"}, 32'(zero), 32'(z));
        check({name, "_negz"}, 32'(neg_zero), 32'(nz));
        check({name, "_equ"}, 32'(equ), 32'(eq));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() > 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string name);
        @(negedge clk);
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_acc"}, 32'(acc), 32'd0);
        check({name, "_carry"}, 32'(carry), 32'd0);
        check({name, "_result"}, 32'(result), 32'd0);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset_checks("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(0, 8'hF0, 8'h20, 0, 0, 0);
        expect_lit("add", 8'h10, 1, 0, 0, 0, 1);
        send(0, 8'hFF, 8'h01, 0, 0, 0);
        expect_lit("add_wrap", 8'h00, 1, 1, 0, 0, 1);
        send(1, 8'h00, 8'h00, 0, 0, 0);
        expect_lit("adc", 8'h01, 0, 0, 0, 1, 1);
        send(2, 8'h05, 8'h07, 0, 0, 0);
        expect_lit("sub_borrow", 8'hFE, 0, 0, 0, 0, 1);
        send(2, 8'h07, 8'h07, 0, 0, 0);
        expect_lit("sub_eq", 8'h00, 1, 1, 0, 1, 1);
        send(2, 8'h07, 8'h07, 0, 0, 1);
        expect_lit("sub_com", 8'hFF, 1, 0, 1, 1, 1);
        send(10, 8'h81, 8'h03, 0, 0, 0);
        expect_lit("shln3", 8'h08, 0, 0, 0, 0, 3);
        send(0, 8'hFF, 8'h01, 0, 0, 0);
        expect_lit("carry_set", 8'h00, 1, 1, 0, 0, 1);
        send(10, 8'h81, 8'h00, 0, 0, 0);
        expect_lit("shln0", 8'h81, 1, 0, 0, 0, 1);

        for (int i = 0; i < 14; i++) begin
            send(s_op[i], s_a[i], s_b[i], s_sa[i], s_we[i], s_cm[i]);
        end
        drain();

        out_ready = 1'b0;
        send(0, 8'h00, 8'h01, 0, 1, 0);
        fork
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("bp_result", 32'(result), 32'h01);
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            begin
                send(0, 8'h55, 8'h01, 1, 1, 0);
                send(0, 8'h55, 8'h01, 1, 1, 0);
            end
        join
        @(negedge clk);
        check("accum_acc", 32'(acc), 32'h03);
        drain();

        send(11, 8'h80, 8'h07, 0, 1, 0);
        repeat (3) begin
            @(negedge clk);
            check("shrn_busy_valid", 32'(out_valid), 32'd0);
        end
        #2;
        rst_n = 1'b0;
        q.delete();
        m_acc = '0;
        m_c   = 1'b0;
        reset_checks("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("post_reset_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(0, 8'h01, 8'h02, 0, 0, 0);
        expect_lit("post_reset_add", 8'h03, 0, 0, 0, 0, 1);

        drain();
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/xalu_seq.md
# xalu_seq

Parametrised sequential successor to the 4-bit ALU slice: a WIDTH-bit ALU with a registered result and flag stage, an accumulator, a persistent carry flag for multi-word chaining, and an iterative multi-bit shifter. Sits between an operand source and a result consumer, with valid/ready handshakes on both sides. Keeps the slice's function set, the complement-output mode and the zero/neg-zero/equal status.

## Interface
- WIDTH, 8, operand/result width (≥2)
- SHW, $clog2(WIDTH), shift-count width (derived)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid & in_ready
- op  in  4  function code (see Operation)
- a_in, b_in  in  WIDTH  operands
- src_acc  in  1  1: operand A = accumulator, 0: A = a_in
- acc_we  in  1  write final result into accumulator
- com  in  1  invert final result (complement mode)
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- result  out  WIDTH  final result (after com)
- carry, zero, neg_zero, equ  out  1 each  registered flags
- acc  out  WIDTH  accumulator value

## Operation
- Ops: 0 ADD A+B; 1 ADC A+B+C; 2 SUB A+~B+1; 3 AND; 4 OR; 5 XOR; 6 PASSA; 7 PASSB; 8 SHL1 (C in at LSB); 9 SHR1 (C in at MSB); 10 SHLN A<<B[SHW-1:0], zero fill; 11 SHRN A>>B[SHW-1:0], zero fill; 12-15 reserved = PASSA, carry unchanged.
- C = internal carry flag register; updated on every completed op.
- Carry out: ADD/ADC/SUB = adder bit WIDTH (SUB: 1 = no borrow, A≥B); SHL1/SHLN = last bit shifted out of MSB; SHR1/SHRN = last bit out of LSB; shift count 0 → carry unchanged; logic/pass ops → 0.
- result = com ? ~r : r; zero = (result==0); neg_zero = (result all ones); equ = (A==B) on captured operands.
- acc_we: acc ← result (post-com) when output is produced.
- FSM states IDLE, SHIFT, HOLD.
  - IDLE: in_ready=1. Accept → single-cycle op or count≤1 → HOLD with result loaded; SHLN/SHRN count≥2 → SHIFT, working reg = A, counter = count.
  - SHIFT: one bit per cycle; counter decrements; at counter==1 final step → HOLD. in_ready=0.
  - HOLD: out_valid=1; out_ready → IDLE. in_ready = out_ready (back-to-back accept permitted same cycle, transitions to new op's state).
- Operands, op, src_acc, acc_we, com captured at accept; later input changes ignored.
- src_acc reads acc value at accept cycle, including a write landing that same edge? No: reads pre-edge value.

## Timing
- Reset (async assert, sync-released use): state IDLE, out_valid 0, result 0, all flags 0, acc 0, C 0.
- Single-cycle ops and shifts with count 0/1: out_valid 1 cycle after accept.
- SHLN/SHRN count n≥2: out_valid n cycles after accept.
- Throughput: one op per cycle when out_ready held high.
- result/flags stable while out_valid & ~out_ready.
- rst_n low mid-SHIFT or HOLD: operation discarded, no acc/C update.

## Structure
- Package xalu_pkg: op code localparams/enum (OP_ADD…OP_SHRN), FSM state enum.
- Sub-module xalu_datapath: combinational single-cycle function unit (adder, logic, pass, 1-bit shifts, carry out); top holds FSM, shift iterator, registers, handshake.

## Test plan
- WIDTH=8: reset → out_valid 0, acc 0, in_ready 1; ADD 0xF0+0x20 → result 0x10, carry 1, 1 cycle latency.
- ADC chain: ADD 0xFF+0x01 (carry 1, zero 1) then ADC 0x00+0x00 → 0x01, carry 0.
- SUB 0x05-0x07 → 0xFE, carry 0; SUB 0x07-0x07 → 0x00, carry 1, zero 1, equ 1; com=1 on same → 0xFF, neg_zero 1.
- SHLN A=0x81, B=3 → out_valid 3 cycles later, result 0x08, carry 0; in_ready 0 during SHIFT; count 0 → result 0x81 in 1 cycle, carry unchanged.
- Backpressure: out_ready low 4 cycles → result held, in_ready 0; release → next op accepted same cycle; src_acc with acc_we accumulates 1+1+1 → acc 0x03.
- rst_n pulsed mid-SHRN → out_valid 0, acc/carry 0, no stale result after release.
